// File: rtl/bpm_band_fusion.sv
// -----------------------------------------------------------------------------
// bpm_band_fusion
//   Fuses NBANDS per-band BPM estimates into one BPM. Out-of-range estimates
//   are dropped. Bands that stop updating for STALE_FRAMES frame ticks age out.
//   The live bands are combined by a weighted average: one band per cycle is
//   accumulated, then a restoring divider produces one quotient bit per cycle,
//   rounding half up. A phase accumulator turns the fused BPM into a beat pulse.
//
//   Optional feature macro: BPM_EMA_EN
//     defined   : final_bpm follows each new result through an exponential
//                 moving average with step 2^-EMA_SHIFT. The first result
//                 after reset is loaded directly.
//     undefined : final_bpm takes each new result directly.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   band_bpm     packed band BPMs, band i at [i*BPM_W +: BPM_W]
//   band_valid   1-cycle strobe per band
//   band_weight  packed static unsigned weights, band i at [i*WEIGHT_W +: WEIGHT_W]
//   frame_tick   1-cycle pulse per analysis frame
//   final_bpm    fused BPM; holds its value between updates
//   final_valid  1-cycle pulse when final_bpm updates
//   beat_pulse   1-cycle pulse per estimated beat
//   band_live    bands currently included in the fusion
//   busy         fusion FSM is not idle
// -----------------------------------------------------------------------------
module bpm_band_fusion #(
   parameter int NBANDS       = 3,
   parameter int BPM_W        = 16,
   parameter int WEIGHT_W     = 4,
   parameter int BPM_MIN      = 40,
   parameter int BPM_MAX      = 240,
   parameter int STALE_FRAMES = 8,
   parameter int CLK_HZ       = 50000000,
   parameter int EMA_SHIFT    = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NBANDS*BPM_W-1:0]      band_bpm,
   input  logic [NBANDS-1:0]            band_valid,
   input  logic [NBANDS*WEIGHT_W-1:0]   band_weight,
   input  logic                         frame_tick,
   output logic [BPM_W-1:0]             final_bpm,
   output logic                         final_valid,
   output logic                         beat_pulse,
   output logic [NBANDS-1:0]            band_live,
   output logic                         busy
);

   localparam int     NUM_W  = BPM_W + WEIGHT_W + $clog2(NBANDS) + 1;
   localparam int     DEN_W  = WEIGHT_W + $clog2(NBANDS) + 1;
   localparam int     IDX_W  = (NBANDS > 1) ? $clog2(NBANDS) : 1;
   localparam int     DCNT_W = (BPM_W > 1) ? $clog2(BPM_W) : 1;
   localparam int     AGE_W  = $clog2(STALE_FRAMES + 1);
   localparam longint THRESH = longint'(CLK_HZ) * 60;
   localparam int     ACC_W  = $clog2(THRESH) + 1;
   localparam int     SUM_W  = ((ACC_W > BPM_W) ? ACC_W : BPM_W) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_OUTPUT} state_t;

   state_t              state_q, state_d;
   logic                pending_q, pending_d;
   logic [BPM_W-1:0]    bpm_q [NBANDS];
   logic [BPM_W-1:0]    bpm_d [NBANDS];
   logic [AGE_W-1:0]    age_q [NBANDS];
   logic [AGE_W-1:0]    age_d [NBANDS];
   logic [NBANDS-1:0]   live_q, live_d;
   logic [NUM_W-1:0]    num_q, num_d;
   logic [DEN_W-1:0]    den_q, den_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
   logic [DEN_W-1:0]    rem_q, rem_d;
   logic [BPM_W-1:0]    quo_q, quo_d;
   logic [BPM_W-1:0]    final_bpm_q, final_bpm_d;
   logic                final_valid_q, final_valid_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                beat_q, beat_d;

   logic [WEIGHT_W-1:0] w_arr [NBANDS];
   logic [BPM_W-1:0]    bpm_in;
   logic [AGE_W-1:0]    age_inc;
   logic [WEIGHT_W-1:0] cur_w;
   logic [BPM_W-1:0]    cur_bpm;
   logic [NUM_W-1:0]    dividend;
   logic [DEN_W-1:0]    rem_in;
   logic [BPM_W-1:0]    low_in;
   logic [DEN_W:0]      trial;
   logic [SUM_W-1:0]    beat_sum;

`ifdef BPM_EMA_EN
   logic                ema_seen_q, ema_seen_d;
   logic signed [BPM_W:0] ema_diff;
   logic signed [BPM_W:0] ema_sum;
`endif

   // NOTE: every combinational output is given a default before any branch,
   // so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q;
      live_d        = live_q;
      num_d         = num_q;
      den_d         = den_q;
      idx_d         = idx_q;
      dcnt_d        = dcnt_q;
      rem_d         = rem_q;
      quo_d         = quo_q;
      final_bpm_d   = final_bpm_q;
      final_valid_d = 1'b0;
      acc_d         = acc_q;
      beat_d        = 1'b0;
      bpm_in        = '0;
      age_inc       = '0;
      dividend      = num_q + NUM_W'(den_q >> 1);
      rem_in        = rem_q;
      low_in        = quo_q;
      trial         = '0;
      beat_sum      = '0;
`ifdef BPM_EMA_EN
      ema_seen_d    = ema_seen_q;
      ema_diff      = '0;
      ema_sum       = '0;
`endif
      for (int i = 0; i < NBANDS; i++) begin
         w_arr[i] = band_weight[i*WEIGHT_W +: WEIGHT_W];
         bpm_d[i] = bpm_q[i];
         age_d[i] = age_q[i];
      end
      cur_w   = w_arr[idx_q];
      cur_bpm = bpm_q[idx_q];

      // The IDLE hand-off clears pending first so that a capture in the
      // same cycle still requests another pass.
      if (state_q == S_IDLE && pending_q)
         pending_d = 1'b0;

      // Band capture and ageing; a capture in the same cycle as a frame
      // tick restarts the age.
      for (int i = 0; i < NBANDS; i++) begin
         bpm_in = band_bpm[i*BPM_W +: BPM_W];
         if (band_valid[i] && bpm_in >= BPM_W'(BPM_MIN) && bpm_in <= BPM_W'(BPM_MAX)) begin
            bpm_d[i]  = bpm_in;
            age_d[i]  = '0;
            live_d[i] = 1'b1;
            pending_d = 1'b1;
         end else if (frame_tick && live_q[i]) begin
            age_inc  = (age_q[i] == AGE_W'(STALE_FRAMES)) ? age_q[i] : age_q[i] + 1'b1;
            age_d[i] = age_inc;
            if (age_inc == AGE_W'(STALE_FRAMES))
               live_d[i] = 1'b0;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (pending_q) begin
               num_d   = '0;
               den_d   = '0;
               idx_d   = '0;
               state_d = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (live_q[idx_q] && cur_w != '0) begin
               num_d = num_q + NUM_W'(cur_w) * NUM_W'(cur_bpm);
               den_d = den_q + DEN_W'(cur_w);
            end
            if (idx_q == IDX_W'(NBANDS - 1)) begin
               dcnt_d  = '0;
               state_d = S_DIVIDE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DIVIDE: begin
            if (dcnt_q == '0 && den_q == '0) begin
               state_d = S_IDLE;
            end else begin
               // The quotient never exceeds BPM_MAX, so the bits above the
               // low BPM_W dividend bits are already a valid remainder.
               if (dcnt_q == '0) begin
                  rem_in = dividend[NUM_W-1:BPM_W];
                  low_in = dividend[BPM_W-1:0];
               end
               trial = {rem_in, low_in[BPM_W-1]};
               if (trial >= {1'b0, den_q}) begin
                  rem_d = DEN_W'(trial - {1'b0, den_q});
                  quo_d = {low_in[BPM_W-2:0], 1'b1};
               end else begin
                  rem_d = DEN_W'(trial);
                  quo_d = {low_in[BPM_W-2:0], 1'b0};
               end
               if (dcnt_q == DCNT_W'(BPM_W - 1))
                  state_d = S_OUTPUT;
               else
                  dcnt_d = dcnt_q + 1'b1;
            end
         end
         S_OUTPUT: begin
`ifdef BPM_EMA_EN
            if (ema_seen_q) begin
               ema_diff    = $signed({1'b0, quo_q}) - $signed({1'b0, final_bpm_q});
               ema_sum     = $signed({1'b0, final_bpm_q}) + (ema_diff >>> EMA_SHIFT);
               final_bpm_d = ema_sum[BPM_W-1:0];
            end else begin
               final_bpm_d = quo_q;
            end
            ema_seen_d    = 1'b1;
`else
            final_bpm_d   = quo_q;
`endif
            final_valid_d = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Beat phase accumulator: one beat per CLK_HZ*60 of accumulated BPM.
      if (final_bpm_q == '0) begin
         acc_d = '0;
      end else begin
         beat_sum = SUM_W'(acc_q) + SUM_W'(final_bpm_q);
         if (beat_sum >= SUM_W'(THRESH)) begin
            acc_d  = ACC_W'(beat_sum - SUM_W'(THRESH));
            beat_d = 1'b1;
         end else begin
            acc_d = ACC_W'(beat_sum);
         end
      end
   end

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples the values of the previous cycle regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         pending_q     <= 1'b0;
         live_q        <= '0;
         num_q         <= '0;
         den_q         <= '0;
         idx_q         <= '0;
         dcnt_q        <= '0;
         rem_q         <= '0;
         quo_q         <= '0;
         final_bpm_q   <= '0;
         final_valid_q <= 1'b0;
         acc_q         <= '0;
         beat_q        <= 1'b0;
`ifdef BPM_EMA_EN
         ema_seen_q    <= 1'b0;
`endif
         // NOTE: the band registers are a handful of flops, not a RAM, so
         // clearing them in reset costs nothing and keeps stale values out.
         for (int i = 0; i < NBANDS; i++) begin
            bpm_q[i] <= '0;
            age_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         live_q        <= live_d;
         num_q         <= num_d;
         den_q         <= den_d;
         idx_q         <= idx_d;
         dcnt_q        <= dcnt_d;
         rem_q         <= rem_d;
         quo_q         <= quo_d;
         final_bpm_q   <= final_bpm_d;
         final_valid_q <= final_valid_d;
         acc_q         <= acc_d;
         beat_q        <= beat_d;
`ifdef BPM_EMA_EN
         ema_seen_q    <= ema_seen_d;
`endif
         for (int i = 0; i < NBANDS; i++) begin
            bpm_q[i] <= bpm_d[i];
            age_q[i] <= age_d[i];
         end
      end
   end

   assign final_bpm   = final_bpm_q;
   assign final_valid = final_valid_q;
   assign beat_pulse  = beat_q;
   assign band_live   = live_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_bpm_band_fusion.sv
// -----------------------------------------------------------------------------
// tb_bpm_band_fusion
//   Self-checking bench for bpm_band_fusion with NBANDS=3, BPM_W=16,
//   STALE_FRAMES=4 and CLK_HZ=100 (beat threshold 6000). Expected fusion
//   results come from a reference model that keeps the band table in arrays
//   and computes the rounded weighted mean with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_bpm_band_fusion;

   localparam int NB    = 3;
   localparam int BW    = 16;
   localparam int WW    = 4;
   localparam int BMIN  = 40;
   localparam int BMAX  = 240;
   localparam int STALE = 4;
   localparam int CLKHZ = 100;
   localparam int ESH   = 2;
   localparam int LAT   = NB + BW + 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [NB*BW-1:0]  band_bpm;
   logic [NB-1:0]     band_valid;
   logic [NB*WW-1:0]  band_weight;
   logic              frame_tick;
   logic [BW-1:0]     final_bpm;
   logic              final_valid;
   logic              beat_pulse;
   logic [NB-1:0]     band_live;
   logic              busy;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int  m_bpm  [NB];
   int  m_age  [NB];
   int  m_w    [NB];
   bit  m_live [NB];
   int  m_final;
   bit  m_seen;

   typedef struct {
      int          b0, b1, b2;
      logic [2:0]  v;
      int          w0, w1, w2;
      int          exp_q;       // -1: no result expected
      logic [2:0]  exp_live;
      string       name;
   } vec_t;

   always #5 clk = ~clk;

   bpm_band_fusion #(
      .NBANDS(NB), .BPM_W(BW), .WEIGHT_W(WW), .BPM_MIN(BMIN), .BPM_MAX(BMAX),
      .STALE_FRAMES(STALE), .CLK_HZ(CLKHZ), .EMA_SHIFT(ESH)
   ) dut (
      .clk(clk), .reset(reset), .band_bpm(band_bpm), .band_valid(band_valid),
      .band_weight(band_weight), .frame_tick(frame_tick), .final_bpm(final_bpm),
      .final_valid(final_valid), .beat_pulse(beat_pulse), .band_live(band_live),
      .busy(busy)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         m_bpm[i] = 0; m_age[i] = 0; m_w[i] = 0; m_live[i] = 0;
      end
      m_final = 0;
      m_seen  = 0;
   endtask

   function automatic int model_q();
      longint num = 0;
      longint den = 0;
      for (int i = 0; i < NB; i++)
         if (m_live[i] && m_w[i] != 0) begin
            num += longint'(m_w[i]) * m_bpm[i];
            den += m_w[i];
         end
      if (den == 0) return -1;
      return int'((num + den / 2) / den);
   endfunction

   function automatic logic [NB-1:0] model_live();
      logic [NB-1:0] l;
      for (int i = 0; i < NB; i++) l[i] = m_live[i];
      return l;
   endfunction

   // Present one set of band strobes, update the model, then wait for the
   // fusion result (or its absence) and compare. exp_q = -2 asks the model.
   task automatic apply(input int b0, input int b1, input int b2, input logic [2:0] v,
                        input int w0, input int w1, input int w2, input bit tick,
                        input int exp_q, input string name);
      int bv [NB];
      bit cap_any;
      int q;
      bit got;
      int n;
      bv[0] = b0; bv[1] = b1; bv[2] = b2;
      @(negedge clk);
      band_bpm    = {BW'(b2), BW'(b1), BW'(b0)};
      band_weight = {WW'(w2), WW'(w1), WW'(w0)};
      band_valid  = v;
      frame_tick  = tick;
      m_w[0] = w0; m_w[1] = w1; m_w[2] = w2;
      cap_any = 0;
      for (int i = 0; i < NB; i++) begin
         if (v[i] && bv[i] >= BMIN && bv[i] <= BMAX) begin
            m_bpm[i] = bv[i]; m_age[i] = 0; m_live[i] = 1; cap_any = 1;
         end else if (tick && m_live[i]) begin
            m_age[i] = (m_age[i] + 1 > STALE) ? STALE : m_age[i] + 1;
            if (m_age[i] >= STALE) m_live[i] = 0;
         end
      end
      q = (exp_q == -2) ? model_q() : exp_q;
      if (!cap_any) q = -1;
      if (q >= 0) begin
`ifdef BPM_EMA_EN
         if (m_seen) m_final = m_final + ((q - m_final) >>> ESH);
         else        m_final = q;
`else
         m_final = q;
`endif
         m_seen = 1;
      end
      @(posedge clk);
      #1;
      band_valid = '0;
      frame_tick = 1'b0;
      got = 0;
      n   = 0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(posedge clk);
         #1;
         if (final_valid) begin
            got = 1;
            n   = k;
         end
      end
      check({name, " result present"}, got, (q >= 0));
      if (got && q >= 0) check({name, " latency"}, n, LAT);
      check({name, " final_bpm"}, final_bpm, m_final);
      check({name, " band_live"}, band_live, model_live());
      if (got) begin
         @(posedge clk);
         #1;
         check({name, " single pulse"}, final_valid, 0);
      end
      check({name, " idle"}, busy, 0);
   endtask

   task automatic measure_beat(input int period, input string name);
      bit found = 0;
      bit found2;
      int cnt;
      for (int k = 0; k < 200 && !found; k++) begin
         @(posedge clk);
         #1;
         if (beat_pulse) found = 1;
      end
      check({name, " first beat"}, found, 1);
      for (int r = 0; r < 2; r++) begin
         found2 = 0;
         cnt    = 0;
         for (int k = 1; k <= 200 && !found2; k++) begin
            @(posedge clk);
            #1;
            if (beat_pulse) begin
               found2 = 1;
               cnt    = k;
            end
         end
         check({name, " beat period"}, cnt, period);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   vec_t vecs [5];

   initial begin
      int nbeat;
      int nvalid;
      int nbusy;
      vecs[0] = '{b0:20,  b1:100, b2:140, v:3'b111, w0:1, w1:1, w2:1, exp_q:120, exp_live:3'b110, name:"out_of_range"};
      vecs[1] = '{b0:120, b1:124, b2:128, v:3'b111, w0:2, w1:1, w2:1, exp_q:123, exp_live:3'b111, name:"weights_211"};
      vecs[2] = '{b0:120, b1:121, b2:121, v:3'b111, w0:1, w1:1, w2:1, exp_q:121, exp_live:3'b111, name:"round_half_up"};
      vecs[3] = '{b0:250, b1:30,  b2:200, v:3'b001, w0:1, w1:1, w2:1, exp_q:-1,  exp_live:3'b111, name:"all_rejected"};
      vecs[4] = '{b0:0,   b1:0,   b2:180, v:3'b100, w0:1, w1:1, w2:1, exp_q:140, exp_live:3'b111, name:"single_update"};

      reset       = 1'b1;
      band_bpm    = '0;
      band_valid  = '0;
      band_weight = '0;
      frame_tick  = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset final_bpm",   final_bpm,   0);
      check("reset final_valid", final_valid, 0);
      check("reset beat_pulse",  beat_pulse,  0);
      check("reset band_live",   band_live,   0);
      check("reset busy",        busy,        0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven vectors
      for (int t = 0; t < 5; t++) begin
         apply(vecs[t].b0, vecs[t].b1, vecs[t].b2, vecs[t].v,
               vecs[t].w0, vecs[t].w1, vecs[t].w2, 1'b0, vecs[t].exp_q, vecs[t].name);
         check({vecs[t].name, " live table"}, band_live, vecs[t].exp_live);
      end

      // Ageing: only band0 keeps updating across four frame ticks
      for (int t = 0; t < STALE; t++)
         apply(100, 0, 0, 3'b001, 1, 1, 1, 1'b1, -2, "ageing");
      check("stale live", band_live, 3'b001);
      apply(110, 0, 0, 3'b001, 3, 7, 9, 1'b0, -2, "band0_alone");
      apply(90, 0, 0, 3'b001, 0, 0, 0, 1'b0, -2, "zero_weights");

      // Beat generator and optional smoothing from a clean reset
      do_reset();
      apply(120, 0, 0, 3'b001, 1, 1, 1, 1'b0, -2, "beat_120");
      measure_beat(50, "bpm120");
      apply(160, 0, 0, 3'b001, 1, 1, 1, 1'b0, -2, "second_result");

      // Randomized traffic against the model
      for (int r = 0; r < 24; r++) begin
         apply(int'($urandom_range(260, 20)), int'($urandom_range(260, 20)),
               int'($urandom_range(260, 20)), 3'($urandom_range(7, 0)),
               int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
               int'($urandom_range(15, 0)), ($urandom_range(3, 0) == 0), -2, "random");
      end

      // Reset in the middle of a fusion with beats running
      @(negedge clk);
      band_bpm    = {BW'(0), BW'(0), BW'(200)};
      band_weight = {WW'(1), WW'(1), WW'(1)};
      band_valid  = 3'b001;
      @(posedge clk);
      #1;
      band_valid = '0;
      repeat (5) @(posedge clk);
      #1;
      check("mid busy before reset", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async final_bpm",   final_bpm,   0);
      check("async final_valid", final_valid, 0);
      check("async beat_pulse",  beat_pulse,  0);
      check("async band_live",   band_live,   0);
      check("async busy",        busy,        0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      nbeat = 0; nvalid = 0; nbusy = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (beat_pulse)  nbeat++;
         if (final_valid) nvalid++;
         if (busy)        nbusy++;
      end
      check("post reset beats",  nbeat,  0);
      check("post reset valids", nvalid, 0);
      check("post reset busy",   nbusy,  0);
      check("post reset bpm",    final_bpm, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bpm_band_fusion.md
Name: bpm_band_fusion

Overview:
Parametrised successor to the fixed three-band BPM combiner. Accepts NBANDS per-band BPM estimates, drops out-of-range values, ages out bands that stop updating, and fuses the live bands with a sequential weighted average using configurable weights and a multi-cycle divider. It also drives a phase-accumulator beat-pulse generator from the fused BPM. Sits after the per-band autocorrelation instances.

Parameters:
NBANDS, 3, number of frequency bands
BPM_W, 16, BPM value width (integer BPM)
WEIGHT_W, 4, unsigned per-band weight width
BPM_MIN, 40, lowest accepted band BPM (inclusive)
BPM_MAX, 240, highest accepted band BPM (inclusive)
STALE_FRAMES, 8, number of frame_tick pulses with no update before a band is dropped
CLK_HZ, 50000000, clk frequency; beat threshold = CLK_HZ*60
EMA_SHIFT, 2, smoothing shift (used only with BPM_EMA_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
band_bpm  in  NBANDS*BPM_W  packed band BPMs; band i at [i*BPM_W +: BPM_W]
band_valid  in  NBANDS  1-cycle strobe per band
band_weight  in  NBANDS*WEIGHT_W  packed static weights
frame_tick  in  1  1-cycle pulse per analysis frame
final_bpm  out  BPM_W  fused BPM; holds its value between updates
final_valid  out  1  1-cycle pulse when final_bpm updates
beat_pulse  out  1  1-cycle pulse per estimated beat
band_live  out  NBANDS  bands included in the fusion
busy  out  1  fusion FSM is not in IDLE

Behaviour:
- Reset (async): all outputs 0, all band registers, ages, pending flag and the accumulator cleared, FSM set to IDLE.
- Band capture: when band_valid[i]=1 and BPM_MIN<=band_bpm[i]<=BPM_MAX: store the value, set age[i]=0, set band_live[i]=1, set pending=1. Out-of-range values are discarded; band state does not change.
- Ageing: each frame_tick increments every live band's age, saturating. A band whose age reaches STALE_FRAMES gets band_live[i]=0. band_valid and frame_tick for the same band in the same cycle: the valid wins (age=0).
- FSM: IDLE -> ACCUM -> DIVIDE -> OUTPUT -> IDLE.
  - IDLE: if pending, clear pending, zero num/den, go to ACCUM.
  - ACCUM: one band per cycle, i=0..NBANDS-1. If band_live[i] and w[i]!=0: num+=w[i]*bpm[i] and den+=w[i]. Band registers are read live; an update during ACCUM/DIVIDE sets pending and forces another pass.
  - DIVIDE: if den==0, return to IDLE with no output change. Otherwise run a restoring divide of (num+den/2) by den at 1 quotient bit per cycle, BPM_W cycles (round-half-up).
  - OUTPUT: load final_bpm, pulse final_valid for 1 cycle, go to IDLE. If pending is set, re-enter ACCUM on the next IDLE cycle.
- Widths:
  - num: BPM_W+WEIGHT_W+clog2(NBANDS)+1
  - den: WEIGHT_W+clog2(NBANDS)+1
  - The quotient is always <= BPM_MAX.
- Latency: with the FSM idle, final_valid rises NBANDS+BPM_W+2 cycles after the edge that samples band_valid.
- Beat generator: accumulator acc of width clog2(CLK_HZ*60)+1.
  - While final_bpm!=0: each cycle acc+=final_bpm. When acc>=CLK_HZ*60, subtract the threshold and pulse beat_pulse.
  - While final_bpm==0: acc=0, no pulses.

Optional Feature:
BPM_EMA_EN
- Defined: on OUTPUT, final_bpm <= final_bpm + ((q - final_bpm) >>> EMA_SHIFT) using signed arithmetic. The first result after reset loads q directly.
- Undefined: final_bpm <= q. EMA_SHIFT is unused.

Test Plan:
- Assert reset mid-fusion with beats running -> final_bpm=0, final_valid=0, beat_pulse=0, band_live=0, busy=0 immediately; no pulses until a new valid arrives.
- NBANDS=3, BPM_W=16, weights 2,1,1, bands 120,124,128 valid in one cycle -> final_bpm=123, a single final_valid exactly 21 cycles later.
- Weights 1,1,1, bands 120,121,121 -> 362/3=120.67, rounds to final_bpm=121.
- band0=20 (out of range), band1=100, band2=140, weights 1,1,1 -> band_live=3'b110, final_bpm=120.
- STALE_FRAMES=4: after the bands are live, 4 frame_ticks with only band0 updating -> band_live=3'b001; next fusion equals band0 alone. All weights 0 -> no final_valid, final_bpm held.
- CLK_HZ=100, final_bpm=120 -> beat_pulse every 50 cycles. With BPM_EMA_EN and EMA_SHIFT=2: results 120 then raw 160 -> final_bpm 120 then 130.
